// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, with
//             one shared full-subtractor cell and a single borrow flip-flop.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_done;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res;

    // Full-subtractor cell operating on the current LSBs.
    assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_br_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
    // Result register content after this bit is shifted in at the MSB.
    assign w_res     = {w_d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_sr    <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_br   <= w_br_next;
                    r_sr   <= w_res;
                    r_cnt  <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_diff  <= w_res;
                        r_bout  <= w_br_next;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign busy = (r_state == S_BUSY);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;

    logic [3:0] diff4;
    logic       bout4, busy4, done4;
    logic [7:0] diff8;
    logic       bout8, busy8, done8;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
    bit         m_busy [2];
    int         m_cnt  [2];
    bit         m_done [2];
    logic [7:0] m_diff [2];
    bit         m_bout [2];
    logic [8:0] sb0[$];
    logic [8:0] sb1[$];
    logic [8:0] m_e;
    int         m_w;
    int         n_done8 = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]), .bin(bin),
        .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {borrow, difference} of (a - b - bin) for a w-bit operation.
    function automatic logic [8:0] exp_of(input logic [7:0] ea, input logic [7:0] eb,
                                          input logic ebin, input int w);
        int mask;
        int r;
        mask = (1 << w) - 1;
        r = (int'(ea) & mask) - (int'(eb) & mask) - int'(ebin);
        return {(r < 0), 8'(r & mask)};
    endfunction

    // Scoreboard model: push on accepted start, pop on completion.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_w = (i == 0) ? 4 : 8;
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_diff[i] = '0;
                m_bout[i] = 1'b0;
                if (i == 0) sb0.delete(); else sb1.delete();
            end else if (m_busy[i]) begin
                m_cnt[i]++;
                m_done[i] = (m_cnt[i] == m_w);
                if (m_done[i]) begin
                    m_busy[i] = 1'b0;
                    if (i == 0) begin
                        check("sb0_empty", 32'(sb0.size() > 0), 32'd1);
                        m_e = (sb0.size() > 0) ? sb0.pop_front() : 9'h0;
                    end else begin
                        check("sb1_empty", 32'(sb1.size() > 0), 32'd1);
                        m_e = (sb1.size() > 0) ? sb1.pop_front() : 9'h0;
                        n_done8++;
                    end
                    m_diff[i] = m_e[7:0];
                    m_bout[i] = m_e[8];
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    if (i == 0) sb0.push_back(exp_of(a, b, bin, 4));
                    else        sb1.push_back(exp_of(a, b, bin, 8));
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy4", 32'(busy4), 32'(m_busy[0]));
            check("done4", 32'(done4), 32'(m_done[0]));
            check("diff4", 32'(diff4), 32'(m_diff[0][3:0]));
            check("bout4", 32'(bout4), 32'(m_bout[0]));
            check("busy8", 32'(busy8), 32'(m_busy[1]));
            check("done8", 32'(done8), 32'(m_done[1]));
            check("diff8", 32'(diff8), 32'(m_diff[1]));
            check("bout8", 32'(bout8), 32'(m_bout[1]));
        end
    end

    // One-shot WIDTH=4 operation with literal expected results and busy length.
    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                           input logic [3:0] ed, input logic eb);
        int nb;
        @(negedge clk);
        a = {4'h0, ta};
        b = {4'h0, tb_};
        bin = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (done4) break;
            if (busy4) nb++;
            @(negedge clk);
        end
        check("op4_done", 32'(done4), 32'd1);
        check("op4_busy_len", 32'(nb), 32'd4);
        check("op4_diff", 32'(diff4), 32'(ed));
        check("op4_bout", 32'(bout4), 32'(eb));
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_diff4", 32'(diff4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_bout8", 32'(bout8), 32'd0);
        rst = 1'b0;

        run_op4(4'd5, 4'd3, 1'b0, 4'd2, 1'b0);
        run_op4(4'd3, 4'd5, 1'b0, 4'hE, 1'b1);
        run_op4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
        run_op4(4'hF, 4'hF, 1'b0, 4'h0, 1'b0);

        // start held high with fresh operands each cycle
        repeat (30) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset two cycles into an operation aborts it
        a = 8'd5;
        b = 8'd3;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_done4", 32'(done4), 32'd0);
            check("abort_diff4", 32'(diff4), 32'd0);
            check("abort_bout4", 32'(bout4), 32'd0);
            check("abort_busy4", 32'(busy4), 32'd0);
        end
        run_op4(4'd9, 4'd4, 1'b0, 4'd5, 1'b0);
        repeat (12) @(negedge clk);

        // random traffic until 1000 WIDTH=8 results have been compared
        n_done8 = 0;
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            if (n_done8 >= 1000) break;
            start = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
        end
        check("rand_count8", 32'(n_done8 >= 1000), 32'd1);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
